// File: rtl/carry_select_sub_pkg.sv
// Shared constants and types for the 8-bit carry-select (borrow-select)
// subtractor.
//   CSS_WIDTH  : full operand width (8)
//   CSS_NIBBLE : width of one select block (4)
//   nibble_t   : one 4-bit slice of an operand
//   nib_res_t  : nibble difference plus the borrow out of that nibble
//   nib_sub()  : x - y - bi over one nibble, returning difference and borrow
package carry_select_sub_pkg;

  localparam int CSS_WIDTH  = 8;
  localparam int CSS_NIBBLE = 4;

  typedef logic [CSS_NIBBLE-1:0] nibble_t;

  typedef struct packed {
    logic    borrow;
    nibble_t d;
  } nib_res_t;

  // With a zero-extended 5-bit subtraction, bit 4 is set exactly when the
  // true result is negative, i.e. when x < y + bi.
  function automatic nib_res_t nib_sub(nibble_t x, nibble_t y, logic bi);
    logic [CSS_NIBBLE:0] t;
    nib_res_t            r;
    t = {1'b0, x} - {1'b0, y} - {{CSS_NIBBLE{1'b0}}, bi};
    r.borrow = t[CSS_NIBBLE];
    r.d      = t[CSS_NIBBLE-1:0];
    return r;
  endfunction

endpackage

// File: rtl/carry_select_subtractor8_if.sv
// Operand/result handshake bundle for carry_select_subtractor8.
//   in_valid/in_ready   : operand transfer (a, b, bin)
//   out_valid/out_ready : result transfer (diff, bout, and ovf when
//                         CARRY_SELECT_SUB_OVF_EN is defined)
// modport master: the producer/consumer side (drives operands, out_ready)
// modport slave : the subtractor side
interface carry_select_subtractor8_if;
  import carry_select_sub_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [CSS_WIDTH-1:0] a;
  logic [CSS_WIDTH-1:0] b;
  logic                 bin;
  logic                 out_valid;
  logic                 out_ready;
  logic [CSS_WIDTH-1:0] diff;
  logic                 bout;
`ifdef CARRY_SELECT_SUB_OVF_EN
  logic                 ovf;
`endif

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout
`ifdef CARRY_SELECT_SUB_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout
`ifdef CARRY_SELECT_SUB_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/csel_sub_nibble.sv
// Combinational 4-bit subtract block for the borrow-select structure.
// Produces x - y under both borrow-in assumptions so the real borrow only
// has to drive a mux.
//   x, y : nibble operands (minuend, subtrahend)
//   r0   : result assuming borrow-in = 0
//   r1   : result assuming borrow-in = 1
module csel_sub_nibble
  import carry_select_sub_pkg::*;
(
  input  nibble_t  x,
  input  nibble_t  y,
  output nib_res_t r0,
  output nib_res_t r1
);

  assign r0 = nib_sub(x, y, 1'b0);
  assign r1 = nib_sub(x, y, 1'b1);

endmodule

// File: rtl/carry_select_subtractor8.sv
// Two-stage pipelined 8-bit unsigned subtractor, borrow-select style.
// diff = (a - b - bin) mod 256, bout = (a < b + bin).
// Stage 1 registers the low nibble result (selected by bin) and both
// high-nibble candidates; stage 2 picks the high candidate with the low
// borrow and registers the outputs.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : carry_select_subtractor8_if.slave (operands, results, handshake)
// Optional feature: define CARRY_SELECT_SUB_OVF_EN to add the signed
// overflow output ovf, aligned with diff.
module carry_select_subtractor8
  import carry_select_sub_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  carry_select_subtractor8_if.slave  bus
);

  nib_res_t lo_r0, lo_r1, hi_r0, hi_r1, lo_sel;

  logic     vld_p1, vld_p2;
  logic     s1_ready, s2_ready;
  logic     in_fire, s1_adv;

  nib_res_t lo_p1, h0_p1, h1_p1;
  nib_res_t hi_sel;

  logic [CSS_WIDTH-1:0] diff_p2;
  logic                 bout_p2;

`ifdef CARRY_SELECT_SUB_OVF_EN
  logic a7_p1, b7_p1;
  logic ovf_p2;

  function automatic logic sub_ovf(logic a7, logic b7, logic d7);
    return (a7 ^ b7) & (d7 ^ a7);
  endfunction
`endif

  csel_sub_nibble u_lo (
    .x  (bus.a[CSS_NIBBLE-1:0]),
    .y  (bus.b[CSS_NIBBLE-1:0]),
    .r0 (lo_r0),
    .r1 (lo_r1)
  );

  csel_sub_nibble u_hi (
    .x  (bus.a[CSS_WIDTH-1:CSS_NIBBLE]),
    .y  (bus.b[CSS_WIDTH-1:CSS_NIBBLE]),
    .r0 (hi_r0),
    .r1 (hi_r1)
  );

  assign lo_sel = bus.bin ? lo_r1 : lo_r0;

  // Ready ripples combinationally back from out_ready (no skid buffer).
  assign s2_ready     = !vld_p2 || bus.out_ready;
  assign s1_ready     = !vld_p1 || s2_ready;
  assign bus.in_ready = s1_ready;
  assign in_fire      = bus.in_valid && s1_ready;
  assign s1_adv       = vld_p1 && s2_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (s1_ready) vld_p1 <= bus.in_valid;
      if (s2_ready) vld_p2 <= vld_p1;
    end
  end

  // ---- stage 1: low result and both high candidates ----
  always_ff @(posedge clk) begin
    if (in_fire) begin
      lo_p1 <= lo_sel;
      h0_p1 <= hi_r0;
      h1_p1 <= hi_r1;
`ifdef CARRY_SELECT_SUB_OVF_EN
      a7_p1 <= bus.a[CSS_WIDTH-1];
      b7_p1 <= bus.b[CSS_WIDTH-1];
`endif
    end
  end

  assign hi_sel = lo_p1.borrow ? h1_p1 : h0_p1;

  // ---- stage 2: select high nibble, register outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_p2 <= '0;
      bout_p2 <= 1'b0;
`ifdef CARRY_SELECT_SUB_OVF_EN
      ovf_p2  <= 1'b0;
`endif
    end else if (s1_adv) begin
      diff_p2 <= {hi_sel.d, lo_p1.d};
      bout_p2 <= hi_sel.borrow;
`ifdef CARRY_SELECT_SUB_OVF_EN
      ovf_p2  <= sub_ovf(a7_p1, b7_p1, hi_sel.d[CSS_NIBBLE-1]);
`endif
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.diff      = diff_p2;
  assign bus.bout      = bout_p2;
`ifdef CARRY_SELECT_SUB_OVF_EN
  assign bus.ovf       = ovf_p2;
`endif

endmodule

// File: tb/tb_carry_select_subtractor8.sv
// Testbench for carry_select_subtractor8: directed cases, backpressure,
// mid-operation reset and a randomized handshake stream, all checked against
// an arithmetic reference model and an in-flight result queue.
module tb_carry_select_subtractor8;
  import carry_select_sub_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  carry_select_subtractor8_if bus ();

  carry_select_subtractor8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  logic last_in_fire;
  logic last_out_fire;

  // Plain integer arithmetic: unsigned difference, borrow as a comparison,
  // overflow as the signed result leaving the 8-bit range.
  function automatic exp_t ref_sub(logic [7:0] a, logic [7:0] b, logic bi);
    int   ia, ib, ibi, r, sa, sb, sr;
    exp_t e;
    ia   = int'(a);
    ib   = int'(b);
    ibi  = bi ? 1 : 0;
    r    = ia - ib - ibi;
    e.d  = 8'(r);
    e.bo = (ia < ib + ibi);
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    sr   = sa - sb - ibi;
    e.ov = (sr < -128) || (sr > 127);
    return e;
  endfunction

  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs already driven; checks this cycle's
  // outputs against the model, records transfers, advances to next negedge.
  task automatic cycle();
    logic inf, outf, exp_rdy;
    exp_t e;
    #1;
    exp_rdy = (q.size() < 2) || bus.out_ready;
    chk1("in_ready", bus.in_ready, exp_rdy);
    inf  = bus.in_valid & bus.in_ready;
    outf = bus.out_valid & bus.out_ready;
    if (bus.out_valid) begin
      if (q.size() == 0) begin
        chk1("spurious_out", bus.out_valid, 1'b0);
      end else begin
        e = q[0];
        chk8("diff", bus.diff, e.d);
        chk1("bout", bus.bout, e.bo);
`ifdef CARRY_SELECT_SUB_OVF_EN
        chk1("ovf", bus.ovf, e.ov);
`endif
        if (outf) void'(q.pop_front());
      end
    end
    if (inf) q.push_back(ref_sub(bus.a, bus.b, bus.bin));
    last_in_fire  = inf;
    last_out_fire = outf;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_check(string tag, logic [7:0] a, logic [7:0] b, logic bi,
                            logic [7:0] ed, logic ebo, logic eov);
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.bin       = bi;
    bus.out_ready = 1'b1;
    cycle();
    chk1({tag, "_accept"}, last_in_fire, 1'b1);
    bus.in_valid = 1'b0;
    chk1({tag, "_lat1_valid"}, bus.out_valid, 1'b0);
    cycle();
    chk1({tag, "_lat2_valid"}, bus.out_valid, 1'b1);
    chk8({tag, "_diff"}, bus.diff, ed);
    chk1({tag, "_bout"}, bus.bout, ebo);
`ifdef CARRY_SELECT_SUB_OVF_EN
    chk1({tag, "_ovf"}, bus.ovf, eov);
`else
    if (eov) chk1({tag, "_ovf_unused"}, eov, eov);
`endif
    cycle();
  endtask

  logic [7:0] ops_a[4];
  logic [7:0] ops_b[4];
  logic       ops_c[4];
  int         accepted;
  logic [7:0] pick[5];

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // reset state
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk8("rst_diff", bus.diff, 8'h00);
    chk1("rst_bout", bus.bout, 1'b0);
    chk1("rst_in_ready", bus.in_ready, 1'b1);
`ifdef CARRY_SELECT_SUB_OVF_EN
    chk1("rst_ovf", bus.ovf, 1'b0);
`endif
    rst = 1'b0;

    // directed arithmetic
    send_check("basic",   8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
    send_check("wrap1",   8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    send_check("wrap2",   8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    send_check("nibsel",  8'h50, 8'h0F, 1'b1, 8'h40, 1'b0, 1'b0);
    send_check("ovf1",    8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    send_check("ovf2",    8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

    // backpressure: 5 stalled cycles, only 2 operands fit
    for (int i = 0; i < 4; i++) begin
      ops_a[i] = 8'($urandom);
      ops_b[i] = 8'($urandom);
      ops_c[i] = 1'($urandom);
    end
    bus.out_ready = 1'b0;
    accepted = 0;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.a        = ops_a[accepted];
      bus.b        = ops_b[accepted];
      bus.bin      = ops_c[accepted];
      cycle();
      if (last_in_fire) accepted++;
    end
    chk8("bp_accepts", 8'(accepted), 8'd2);
    chk1("bp_held_valid", bus.out_valid, 1'b1);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (accepted < 4) begin
        bus.in_valid = 1'b1;
        bus.a        = ops_a[accepted];
        bus.b        = ops_b[accepted];
        bus.bin      = ops_c[accepted];
      end else begin
        bus.in_valid = 1'b0;
      end
      cycle();
      if (last_in_fire) accepted++;
      chk1("bp_stream", last_out_fire, 1'b1);
    end
    chk8("bp_drained", 8'(q.size()), 8'd0);

    // reset with both stages valid
    bus.out_ready = 1'b0;
    for (int c = 0; c < 4 && q.size() < 2; c++) begin
      bus.in_valid = 1'b1;
      bus.a        = 8'($urandom);
      bus.b        = 8'($urandom);
      bus.bin      = 1'($urandom);
      cycle();
    end
    chk8("mr_filled", 8'(q.size()), 8'd2);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    chk1("mr_out_valid", bus.out_valid, 1'b0);
    chk8("mr_diff", bus.diff, 8'h00);
    chk1("mr_bout", bus.bout, 1'b0);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk1("mr_no_stale", bus.out_valid, 1'b0);
    end

    // randomized stream with random stalls, biased toward edge operands
    pick[0] = 8'h00; pick[1] = 8'hFF; pick[2] = 8'h80; pick[3] = 8'h7F;
    for (int c = 0; c < 400; c++) begin
      pick[4]       = 8'($urandom);
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.out_ready = ($urandom_range(2) != 0);
      bus.a         = pick[$urandom_range(4)];
      bus.b         = pick[$urandom_range(4)];
      if ($urandom_range(1) == 1) bus.a = 8'($urandom);
      bus.bin       = 1'($urandom);
      cycle();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10 && q.size() > 0; c++) cycle();
    chk8("final_drained", 8'(q.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
